// File: rtl/ifetch_if.sv
// Fetch-side bus bundle: instruction memory read channel plus the decode handoff.
// The master view belongs to ifetch, the slave view to memory/decode.
interface ifetch_if #(
  parameter int word_size = 16,
  parameter int mem_size  = 8
);
  logic                 mem_req;
  logic [mem_size-1:0]  mem_addr;
  logic                 mem_ack;
  logic [word_size-1:0] mem_rdata;
  logic [word_size-1:0] ir;
  logic [word_size-1:0] ir_pc;
  logic                 ir_valid;
  logic                 ir_ready;

  modport master (
    output mem_req, mem_addr, ir, ir_pc, ir_valid,
    input  mem_ack, mem_rdata, ir_ready
  );

  modport slave (
    input  mem_req, mem_addr, ir, ir_pc, ir_valid,
    output mem_ack, mem_rdata, ir_ready
  );
endinterface

// File: rtl/ifetch.sv
// ifetch: fetches the word at the PC over req/ack, buffers two {pc, word} entries for decode
// and pulses a one-word advance to the PC. Define IFETCH_TIMEOUT_EN for the memory timeout/HALT.
module ifetch #(
  parameter int word_size      = 16,
  parameter int mem_size       = 8,
  parameter int offset_size    = 4,
  parameter int timeout_cycles = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [word_size-1:0]   pc_addr,
  output logic [offset_size-1:0] offset,
  input  logic                   flush,
  output logic                   fetch_err,
  ifetch_if.master               bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SETTLE = 2'd2,
    HALT   = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic                 mem_req_r, mem_req_s;
  logic [mem_size-1:0]  mem_addr_r, mem_addr_s;
  logic [word_size-1:0] fetch_pc_r, fetch_pc_s;
  logic                 offset_r, offset_s;
  logic [1:0]           count_r, count_s;
  logic [word_size-1:0] head_data_r, head_data_s, head_pc_r, head_pc_s;
  logic [word_size-1:0] tail_data_r, tail_data_s, tail_pc_r, tail_pc_s;
  logic                 ir_valid_r, ir_valid_s;
  logic                 push_s, pop_s;

`ifdef IFETCH_TIMEOUT_EN
  localparam int wait_w = ($clog2(timeout_cycles + 1) < 4) ? 4 : $clog2(timeout_cycles + 1);
  logic [wait_w-1:0] wait_r, wait_s;
  logic              err_r, err_s;
`endif

  // mem_req is high exactly in REQ, so an ack outside REQ never pushes
  assign push_s = (state_r == REQ) && bus.mem_ack && !flush;
  assign pop_s  = ir_valid_r && bus.ir_ready;

  // Fetch sequencer next-state and request/advance control
  always_comb begin
    state_s    = state_r;
    mem_req_s  = mem_req_r;
    mem_addr_s = mem_addr_r;
    fetch_pc_s = fetch_pc_r;
    offset_s   = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
    wait_s     = wait_r;
    err_s      = err_r;
`endif
    if (flush) begin
      state_s   = IDLE;
      mem_req_s = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      err_s     = 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (count_r < 2'd2) begin
            mem_addr_s = pc_addr[mem_size-1:0];
            fetch_pc_s = pc_addr;
            mem_req_s  = 1'b1;
            state_s    = REQ;
`ifdef IFETCH_TIMEOUT_EN
            wait_s     = '0;
`endif
          end else begin
            state_s = IDLE;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            mem_req_s = 1'b0;
            offset_s  = 1'b1;
            state_s   = SETTLE;
          end else begin
`ifdef IFETCH_TIMEOUT_EN
            if (wait_r == wait_w'(timeout_cycles - 1)) begin
              mem_req_s = 1'b0;
              err_s     = 1'b1;
              state_s   = HALT;
            end else begin
              wait_s = wait_r + {{(wait_w-1){1'b0}}, 1'b1};
            end
`else
            state_s = REQ;
`endif
          end
        end
        SETTLE:  state_s = IDLE;
        HALT:    state_s = HALT;
        default: begin
          state_s   = IDLE;
          mem_req_s = 1'b0;
        end
      endcase
    end
  end

  // Two-entry buffer: head feeds decode directly, tail is zero whenever fewer than two entries
  always_comb begin
    head_data_s = head_data_r;
    head_pc_s   = head_pc_r;
    tail_data_s = tail_data_r;
    tail_pc_s   = tail_pc_r;
    count_s     = count_r;
    if (flush) begin
      head_data_s = '0;
      head_pc_s   = '0;
      tail_data_s = '0;
      tail_pc_s   = '0;
      count_s     = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_data_s = bus.mem_rdata;
            head_pc_s   = fetch_pc_r;
          end else begin
            tail_data_s = bus.mem_rdata;
            tail_pc_s   = fetch_pc_r;
          end
          count_s = count_r + 2'd1;
        end
        2'b01: begin
          head_data_s = tail_data_r;
          head_pc_s   = tail_pc_r;
          tail_data_s = '0;
          tail_pc_s   = '0;
          count_s     = count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            head_data_s = bus.mem_rdata;
            head_pc_s   = fetch_pc_r;
          end else begin
            head_data_s = tail_data_r;
            head_pc_s   = tail_pc_r;
            tail_data_s = bus.mem_rdata;
            tail_pc_s   = fetch_pc_r;
          end
        end
        default: count_s = count_r;
      endcase
    end
    ir_valid_s = (count_s != 2'd0);
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      mem_req_r  <= 1'b0;
      mem_addr_r <= '0;
      fetch_pc_r <= '0;
      offset_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      mem_req_r  <= mem_req_s;
      mem_addr_r <= mem_addr_s;
      fetch_pc_r <= fetch_pc_s;
      offset_r   <= offset_s;
    end
  end

  // Buffer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_data_r <= '0;
      head_pc_r   <= '0;
      tail_data_r <= '0;
      tail_pc_r   <= '0;
      count_r     <= 2'd0;
      ir_valid_r  <= 1'b0;
    end else begin
      head_data_r <= head_data_s;
      head_pc_r   <= head_pc_s;
      tail_data_r <= tail_data_s;
      tail_pc_r   <= tail_pc_s;
      count_r     <= count_s;
      ir_valid_r  <= ir_valid_s;
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  // Timeout counter and sticky error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_r <= '0;
      err_r  <= 1'b0;
    end else begin
      wait_r <= wait_s;
      err_r  <= err_s;
    end
  end

  assign fetch_err = err_r;
`else
  assign fetch_err = 1'b0;
`endif

  assign offset       = {{(offset_size-1){1'b0}}, offset_r};
  assign bus.mem_req  = mem_req_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.ir       = head_data_r;
  assign bus.ir_pc    = head_pc_r;
  assign bus.ir_valid = ir_valid_r;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: drives a PC register, instruction memory and decode around the DUT and
// checks it against an in-order {pc, word} stream model plus an occupancy counter.
module tb_ifetch;
  localparam int WS = 16;
  localparam int MS = 8;
  localparam int OS = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [WS-1:0] pc_addr;
  logic [OS-1:0] offset;
  logic          flush;
  logic          fetch_err;

  ifetch_if #(.word_size(WS), .mem_size(MS)) bus();

  ifetch #(.word_size(WS), .mem_size(MS), .offset_size(OS), .timeout_cycles(TO)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .offset(offset),
    .flush(flush), .fetch_err(fetch_err), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [WS-1:0] mem [256];
  int            n_checks = 0;
  int            n_fails  = 0;
  int            occ, edge_occ, off_cnt, pop_cnt, rise_cnt, req_run;
  logic [WS-1:0] exp_pc;
  bit            exp_off, prev_req, exp_err;
  logic [MS-1:0] prev_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample/check at negedge, drive inputs, advance the model and the PC.
  task automatic step(input bit ack_en, input bit ready, input bit flsh, input logic [WS-1:0] target);
    bit            push, pop;
    logic [WS-1:0] pc_next;
    check("offset", 32'(offset), {31'd0, exp_off});
    check("ir_valid", 32'(bus.ir_valid), 32'(occ != 0));
    check("occ_le_2", 32'(occ <= 2), 32'd1);
    check("fetch_err", 32'(fetch_err), {31'd0, exp_err});
    if (!bus.ir_valid) begin
      check("ir_empty", 32'(bus.ir), 32'd0);
      check("ir_pc_empty", 32'(bus.ir_pc), 32'd0);
    end
    if (prev_req && bus.mem_req) check("addr_hold", 32'(bus.mem_addr), 32'(prev_addr));
    if (!prev_req && bus.mem_req) begin
      rise_cnt++;
      check("req_addr", 32'(bus.mem_addr), 32'(pc_addr[MS-1:0]));
      check("req_space", 32'(edge_occ < 2), 32'd1);
    end
    if (offset != '0) off_cnt++;

    bus.mem_ack   = ack_en;
    bus.mem_rdata = bus.mem_req ? mem[bus.mem_addr] : 16'($urandom);
    bus.ir_ready  = ready;
    flush         = flsh;

    pop  = bus.ir_valid && ready && !flsh;
    push = bus.mem_req && ack_en && !flsh;
    if (pop) begin
      check("pop_pc", 32'(bus.ir_pc), 32'(exp_pc));
      check("pop_word", 32'(bus.ir), 32'(mem[exp_pc[MS-1:0]]));
      exp_pc = exp_pc + 16'd1;
      pop_cnt++;
    end
`ifdef IFETCH_TIMEOUT_EN
    if (flsh) exp_err = 1'b0;
    else if (bus.mem_req && !ack_en && req_run == TO - 1) exp_err = 1'b1;
    req_run = (bus.mem_req && !ack_en && !flsh) ? req_run + 1 : 0;
`endif
    edge_occ  = occ;
    prev_req  = bus.mem_req;
    prev_addr = bus.mem_addr;
    occ       = flsh ? 0 : occ + int'(push) - int'(pop);
    exp_off   = push;
    pc_next   = flsh ? target : pc_addr + 16'(offset);
    if (flsh) exp_pc = target;
    @(posedge clk);
    #1 pc_addr = pc_next;
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle; returns at a negedge with reset released.
  task automatic reset_mid(input logic [WS-1:0] new_pc);
    #1 rst = 1'b0;
    #1;
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_offset", 32'(offset), 32'd0);
    check("rst_ir", 32'(bus.ir), 32'd0);
    check("rst_ir_pc", 32'(bus.ir_pc), 32'd0);
    check("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);
    bus.mem_ack  = 1'b0;
    bus.ir_ready = 1'b0;
    flush        = 1'b0;
    pc_addr      = new_pc;
    occ = 0; edge_occ = 0; exp_off = 1'b0; prev_req = 1'b0; exp_err = 1'b0; req_run = 0;
    exp_pc = new_pc;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int stall, hi;
    bit ack, rdy, fl;
    rst = 1'b0; pc_addr = '0; flush = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.ir_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    @(negedge clk);

    // Reset mid-request with a buffered entry, then refetch from 0x0012
    reset_mid(16'h0011);
    repeat (3) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    check("t1_req", 32'(bus.mem_req), 32'd1);
    check("t1_addr", 32'(bus.mem_addr), 32'h12);
    reset_mid(16'h0012);
    step(1'b0, 1'b0, 1'b0, '0);
    check("t1_req_after", 32'(bus.mem_req), 32'd1);
    check("t1_addr_after", 32'(bus.mem_addr), 32'h12);

    // Streaming from PC 0 with single-cycle ack
    reset_mid(16'h0000);
    off_cnt = 0; pop_cnt = 0;
    repeat (9) step(1'b1, 1'b1, 1'b0, '0);
    check("t2_offsets", 32'(off_cnt), 32'd3);
    check("t2_pops", 32'(pop_cnt), 32'd3);

    // Backpressure: two entries buffered, no third request, then drain and resume
    reset_mid(16'h0030);
    rise_cnt = 0;
    repeat (12) step(1'b1, 1'b0, 1'b0, '0);
    check("t3_rises", 32'(rise_cnt), 32'd2);
    check("t3_head", 32'(bus.ir_pc), 32'h30);
    repeat (8) step(1'b1, 1'b1, 1'b0, '0);
    check("t3_resume", 32'(rise_cnt > 2), 32'd1);

    // Flush in the same cycle as an ack of 0xBEEF
    reset_mid(16'h0005);
    repeat (3) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    check("t4_req", 32'(bus.mem_req), 32'd1);
    mem[bus.mem_addr] = 16'hBEEF;
    step(1'b1, 1'b0, 1'b1, 16'h0040);
    check("t4_valid", 32'(bus.ir_valid), 32'd0);
    check("t4_offset", 32'(offset), 32'd0);
    step(1'b0, 1'b1, 1'b0, '0);
    check("t4_req_new", 32'(bus.mem_req), 32'd1);
    check("t4_addr_new", 32'(bus.mem_addr), 32'h40);

    // Simultaneous push and pop with one entry buffered
    reset_mid(16'h0020);
    repeat (4) step(1'b1, 1'b0, 1'b0, '0);
    check("t5_req", 32'(bus.mem_req), 32'd1);
    step(1'b1, 1'b1, 1'b0, '0);
    check("t5_valid", 32'(bus.ir_valid), 32'd1);
    check("t5_head_pc", 32'(bus.ir_pc), 32'h21);
    check("t5_head_word", 32'(bus.ir), 32'(mem[8'h21]));
    step(1'b0, 1'b1, 1'b0, '0);

    // Memory never acknowledges
    reset_mid(16'h0050);
    step(1'b0, 1'b1, 1'b0, '0);
`ifdef IFETCH_TIMEOUT_EN
    hi = 0;
    for (int i = 0; i < 40 && !fetch_err; i++) begin
      if (bus.mem_req) hi++;
      step(1'b0, 1'b1, 1'b0, '0);
    end
    check("t6_err", 32'(fetch_err), 32'd1);
    check("t6_req_drop", 32'(bus.mem_req), 32'd0);
    check("t6_req_cycles", 32'(hi), 32'(TO));
    repeat (5) step(1'b0, 1'b1, 1'b0, '0);
    check("t6_halted", 32'(bus.mem_req), 32'd0);
    step(1'b0, 1'b1, 1'b1, 16'h0060);
    check("t6_err_clear", 32'(fetch_err), 32'd0);
    step(1'b0, 1'b1, 1'b0, '0);
    check("t6_restart", 32'(bus.mem_req), 32'd1);
    check("t6_restart_addr", 32'(bus.mem_addr), 32'h60);
`else
    hi = 0;
    repeat (30) step(1'b0, 1'b1, 1'b0, '0);
    check("t6_wait_req", 32'(bus.mem_req), 32'd1);
    check("t6_wait_addr", 32'(bus.mem_addr), 32'h50);
    check("t6_no_err", 32'(fetch_err), 32'd0);
`endif

    // Randomized traffic: ack latency, spurious acks, backpressure and redirects
    reset_mid(16'($urandom));
    stall = 0; pop_cnt = 0;
    repeat (3000) begin
      if (bus.mem_req) ack = (stall >= 8) || ($urandom_range(0, 2) != 0);
      else ack = ($urandom_range(0, 7) == 0);
      stall = (bus.mem_req && !ack) ? stall + 1 : 0;
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 24) == 0);
      step(ack, rdy, fl, 16'($urandom));
    end
    check("rand_progress", 32'(pop_cnt > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit: the consumer of the program counter's `pc_counter` output and the driver of its `offset` increment input. It reads the instruction at the current PC from instruction memory over a req/ack handshake and buffers up to two fetched words with their PCs. It presents them to decode over a valid/ready handshake and pulses a one-word advance back to the PC after each successful fetch. It sits between the PC register, instruction memory and the decode stage.

## Interface

Parameters:
- `word_size`, 16, width of PC, instruction and memory data.
- `mem_size`, 8, instruction memory address width; `mem_addr` = `pc_addr[mem_size-1:0]`.
- `offset_size`, 4, width of the advance output; must match the PC's offset input.
- `timeout_cycles`, 15, cycles `mem_req` may stay unacknowledged (used only with the `IFETCH_TIMEOUT_EN` macro).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pc_addr`  in  word_size  current PC value (PC `pc_counter`).
- `offset`  out  offset_size  advance amount to the PC; 1 for one cycle per fetch, else 0.
- `mem_req`  out  1  instruction memory read request.
- `mem_addr`  out  mem_size  read address, stable while `mem_req`=1.
- `mem_ack`  in  1  read complete; `mem_rdata` valid in the same cycle.
- `mem_rdata`  in  word_size  instruction word.
- `ir`  out  word_size  head instruction.
- `ir_pc`  out  word_size  PC of head instruction.
- `ir_valid`  out  1  head entry valid.
- `ir_ready`  in  1  decode accepts head.
- `flush`  in  1  decode is redirecting the PC (asserted in the same cycle as PC `load_pc`/`branch`).
- `fetch_err`  out  1  sticky memory-timeout flag.

## Operation

- States: IDLE, REQ, SETTLE, HALT. `count` tracks 2-entry FIFO occupancy (0..2).
- IDLE: if `count`<2, register `mem_addr`<=`pc_addr[mem_size-1:0]` and the full `pc_addr` as the fetch PC, set `mem_req`<=1, go to REQ. Otherwise stay in IDLE.
- REQ: `mem_req`=1 and `mem_addr` held. On an edge with `mem_ack`=1:
  - write {fetch PC, `mem_rdata`} to the FIFO tail;
  - set `mem_req`<=0 and `offset`<=1;
  - go to SETTLE.
- SETTLE: `offset`=1 for exactly this cycle, so the PC adds 1 at the end of it. Next state is IDLE with `offset`<=0. The next fetch therefore sees the updated `pc_addr`.
- Pop: occurs on an edge with `ir_valid`&&`ir_ready`. `ir_valid` = (`count`!=0). `ir`/`ir_pc` show the head entry and are 0 when the FIFO is empty.
- Simultaneous push and pop: `count` is unchanged and FIFO order is preserved. A push when `count`=2 cannot occur because IDLE gates on space.
- `flush` has top priority on any edge. It sets `count`<=0, `mem_req`<=0 and `offset`<=0, and the state goes to IDLE. A `mem_ack` in the same cycle is ignored and no push occurs. An ack arriving later (with `mem_req`=0) is also ignored. `flush` also clears `fetch_err` and leaves HALT.
- Arithmetic: no wrap-around handling is needed; `mem_addr` truncates `pc_addr`. `count` never exceeds 2 or goes below 0. A pop when empty is ignored.
- Reset (async, any state, including mid-request): state IDLE, `count` 0, all outputs 0 (`mem_req`, `mem_addr`, `offset`, `ir`, `ir_pc`, `ir_valid`, `fetch_err`).

## Timing

- Minimum fetch loop is 3 cycles per instruction with single-cycle ack: IDLE, then REQ (ack), then SETTLE.
- Fetch latency: `mem_req` rises 1 cycle after IDLE with space. The entry is visible (`ir_valid`=1) the cycle after the ack edge.
- `offset` is registered. It is high for exactly one cycle (SETTLE) per accepted ack, never during REQ or IDLE, and never after a flush.
- `mem_addr` must not change while `mem_req`=1.
- After `flush`, the first new `mem_req` appears 1 cycle later (IDLE, then REQ) using the redirected `pc_addr`.

## Configuration

- `IFETCH_TIMEOUT_EN` defined:
  - A 4-bit-or-wider wait counter runs in REQ and clears on entry to REQ.
  - When the counter reaches `timeout_cycles` without an ack, `mem_req`<=0, `fetch_err`<=1 and the state goes to HALT. No further requests are issued until `flush` or reset.
  - FIFO contents remain poppable in HALT.
- `IFETCH_TIMEOUT_EN` undefined: REQ waits indefinitely, HALT is unreachable and `fetch_err` is tied to 0.

## Test plan

- Reset mid-REQ, with `mem_req`=1 and `pc_addr`=0x0012 -> all outputs 0 immediately. After release, the first `mem_req` has `mem_addr`=0x12.
- Ack in 1 cycle, `ir_ready`=1, `pc_addr` following `offset` from 0 -> instructions at PC 0,1,2 appear in order. `offset`=1 exactly one cycle in three, and `ir_pc` matches each word.
- `ir_ready`=0, three fetch opportunities -> two entries buffered, `count`=2, no third `mem_req`. Raising `ir_ready` pops PC 0 then 1, then fetching resumes.
- `flush` in the same cycle as `mem_ack` (rdata 0xBEEF) -> no push, `ir_valid`=0 next cycle, no `offset` pulse. The next request uses the new `pc_addr` (0x0040).
- Simultaneous push and pop with `count`=1 -> `count` stays 1 and the head advances to the older entry's successor.
- With `IFETCH_TIMEOUT_EN`, `mem_ack` held 0 -> `fetch_err`=1 after 15 REQ cycles and `mem_req` drops. `flush` clears the flag and fetching restarts.
